// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU (alu_seq).

package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Input/output handshake bundle for alu_seq; overflowOutput exists only with ALU_OVERFLOW_EN.

interface alu_seq_if #(
  parameter int WIDTH = 16
) ();

  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic [2:0]       opCode;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] outputALU;
  logic             zeroOutput;
`ifdef ALU_OVERFLOW_EN
  logic             overflowOutput;

  modport master (
    output inValid, input1, input2, opCode, outReady,
    input  inReady, outValid, outputALU, zeroOutput, overflowOutput
  );

  modport slave (
    input  inValid, input1, input2, opCode, outReady,
    output inReady, outValid, outputALU, zeroOutput, overflowOutput
  );
`else
  modport master (
    output inValid, input1, input2, opCode, outReady,
    input  inReady, outValid, outputALU, zeroOutput
  );

  modport slave (
    input  inValid, input1, input2, opCode, outReady,
    output inReady, outValid, outputALU, zeroOutput
  );
`endif

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: WIDTH steps after start, low WIDTH bits of a*b.

module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcandQ;
  logic [WIDTH-1:0] mplierQ;
  logic [WIDTH-1:0] accQ;
  logic [CW-1:0]    cntQ;
  logic             busyQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcandQ  <= '0;
      mplierQ <= '0;
      accQ    <= '0;
      cntQ    <= '0;
      busyQ   <= 1'b0;
    end else if (start) begin
      mcandQ  <= a;
      mplierQ <= b;
      accQ    <= '0;
      cntQ    <= CW'(WIDTH);
      busyQ   <= 1'b1;
    end else if (busyQ) begin
      if (mplierQ[0]) accQ <= accQ + mcandQ;
      mcandQ  <= mcandQ << 1;
      mplierQ <= mplierQ >> 1;
      cntQ    <= cntQ - CW'(1);
      if (cntQ == CW'(1)) busyQ <= 1'b0;
    end
  end

  // The final step is folded in combinationally so the caller can register it on the last edge.
  assign done    = busyQ && (cntQ == CW'(1));
  assign product = accQ + (mplierQ[0] ? mcandQ : '0);

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with iterative MUL and one-entry result buffer.
// Optional ALU_OVERFLOW_EN adds a registered signed-overflow flag for ADD/SUB.

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  state_t           stateQ, stateD;
  logic [WIDTH-1:0] resultQ, resultD;
  logic             zeroQ, zeroD;
  logic [WIDTH-1:0] sum, diff, aluRes, mulProduct;
  logic             accept, isMul, mulDone, sltBit;

  assign bus.inReady = rst_n & ((stateQ == ST_IDLE) | ((stateQ == ST_DONE) & bus.outReady));
  assign accept      = bus.inValid & bus.inReady;
  assign isMul       = (bus.opCode == OP_MUL);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept & isMul),
    .a      (bus.input1),
    .b      (bus.input2),
    .done   (mulDone),
    .product(mulProduct)
  );

  assign sum    = bus.input1 + bus.input2;
  assign diff   = bus.input1 - bus.input2;
  assign sltBit = $signed(bus.input1) < $signed(bus.input2);

  always_comb begin
    aluRes = '0;
    case (bus.opCode)
      OP_ADD:  aluRes = sum;
      OP_SUB:  aluRes = diff;
      OP_AND:  aluRes = bus.input1 & bus.input2;
      OP_OR:   aluRes = bus.input1 | bus.input2;
      OP_XOR:  aluRes = bus.input1 ^ bus.input2;
      OP_SLT:  aluRes = {{(WIDTH-1){1'b0}}, sltBit};
      OP_SLL:  aluRes = bus.input1 << bus.input2[SHW-1:0];
      default: aluRes = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  logic ovfQ, ovfD, aluOvf;
  logic signA, signB;

  assign signA = bus.input1[WIDTH-1];
  assign signB = bus.input2[WIDTH-1];

  always_comb begin
    aluOvf = 1'b0;
    if (bus.opCode == OP_ADD) aluOvf = (signA == signB) && (sum[WIDTH-1] != signA);
    if (bus.opCode == OP_SUB) aluOvf = (signA != signB) && (diff[WIDTH-1] != signA);
  end
`endif

  always_comb begin
    stateD  = stateQ;
    resultD = resultQ;
    zeroD   = zeroQ;
`ifdef ALU_OVERFLOW_EN
    ovfD    = ovfQ;
`endif
    case (stateQ)
      ST_IDLE, ST_DONE: begin
        if (stateQ == ST_DONE && bus.outReady) stateD = ST_IDLE;
        if (accept) begin
          stateD = isMul ? ST_BUSY : ST_DONE;
          // MUL leaves the old result in place; outValid is low until the product lands.
          if (!isMul) begin
            resultD = aluRes;
            zeroD   = (aluRes == '0);
`ifdef ALU_OVERFLOW_EN
            ovfD    = aluOvf;
`endif
          end
        end
      end
      ST_BUSY: begin
        if (mulDone) begin
          stateD  = ST_DONE;
          resultD = mulProduct;
          zeroD   = (mulProduct == '0);
`ifdef ALU_OVERFLOW_EN
          ovfD    = 1'b0;
`endif
        end
      end
      default: stateD = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ  <= ST_IDLE;
      resultQ <= '0;
      zeroQ   <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      ovfQ    <= 1'b0;
`endif
    end else begin
      stateQ  <= stateD;
      resultQ <= resultD;
      zeroQ   <= zeroD;
`ifdef ALU_OVERFLOW_EN
      ovfQ    <= ovfD;
`endif
    end
  end

  assign bus.outValid   = (stateQ == ST_DONE);
  assign bus.outputALU  = resultQ;
  assign bus.zeroOutput = zeroQ;
`ifdef ALU_OVERFLOW_EN
  assign bus.overflowOutput = ovfQ;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus a randomized stream against a reference model.

module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq_if #(.WIDTH(8)) bus8 ();

  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  alu_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int errors = 0;
  int checks = 0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference: plain integer arithmetic, truncated to W bits.
  function automatic logic [W-1:0] refAlu(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint ua, ub, sa, sb, r;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: r = ua + ub;
      3'd1: r = ua - ub;
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (sa < sb) ? 1 : 0;
      3'd6: r = ua << (ub % W);
      default: r = ua * ub;
    endcase
    return W'(r);
  endfunction

  function automatic logic refOvf(input logic [2:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
    longint sa, sb, s, lim;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = longint'(1) << (W - 1);
    if (op == OP_ADD) s = sa + sb;
    else if (op == OP_SUB) s = sa - sb;
    else return 1'b0;
    return (s >= lim) || (s < -lim);
  endfunction

  // Issue one op from idle, measure cycles to outValid, check result, then drain.
  task automatic runOp(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp, input logic expOvf,
                       input int expLat);
    int lat, low;
    bus.inValid  = 1'b1;
    bus.opCode   = op;
    bus.input1   = a;
    bus.input2   = b;
    bus.outReady = 1'b1;
    #1;
    checkVal({tag, "_inReady"}, 64'(bus.inReady), 'h1);
    tick();
    bus.inValid = 1'b0;
    bus.input1  = W'($urandom);
    bus.input2  = W'($urandom);
    bus.opCode  = 3'($urandom_range(0, 7));
    lat = 1;
    low = 0;
    while (!bus.outValid && lat < 60) begin
      if (!bus.inReady) low++;
      tick();
      lat++;
    end
    checkVal({tag, "_lat"}, 64'(lat), 64'(expLat));
    checkVal({tag, "_res"}, 64'(bus.outputALU), 64'(exp));
    checkVal({tag, "_zero"}, 64'(bus.zeroOutput), 64'(exp == '0));
    if (op == OP_MUL) checkVal({tag, "_busyCycles"}, 64'(low), 64'(W));
`ifdef ALU_OVERFLOW_EN
    checkVal({tag, "_ovf"}, 64'(bus.overflowOutput), 64'(expOvf));
`else
    if (expOvf) checkVal({tag, "_ovfUnbuilt"}, 64'(bus.outValid), 'h1);
`endif
    tick();
  endtask

  logic [W:0] sbq[$];
  logic [W:0] e;
  logic       holdPend;
  logic [W-1:0] holdRes;
  int lat, stale;

  initial begin
    bus.inValid  = 1'b0;
    bus.outReady = 1'b1;
    bus.opCode   = '0;
    bus.input1   = '0;
    bus.input2   = '0;
    bus8.inValid  = 1'b0;
    bus8.outReady = 1'b1;
    bus8.opCode   = '0;
    bus8.input1   = '0;
    bus8.input2   = '0;

    // Reset state
    repeat (2) tick();
    checkVal("rst_outValid", 64'(bus.outValid), 'h0);
    checkVal("rst_result", 64'(bus.outputALU), 'h0);
    checkVal("rst_zero", 64'(bus.zeroOutput), 'h0);
    checkVal("rst_inReady", 64'(bus.inReady), 'h0);
`ifdef ALU_OVERFLOW_EN
    checkVal("rst_ovf", 64'(bus.overflowOutput), 'h0);
`endif
    rst_n = 1'b1;
    #1;
    checkVal("post_rst_inReady", 64'(bus.inReady), 'h1);

    runOp("add", OP_ADD, 'h0007, 'h0007, 'h000E, 1'b0, 1);

    // Back-to-back SUB then AND
    bus.inValid = 1'b1; bus.opCode = OP_SUB; bus.input1 = 'h0007; bus.input2 = 'h0007;
    tick();
    checkVal("b2b_sub_valid", 64'(bus.outValid), 'h1);
    checkVal("b2b_sub_res", 64'(bus.outputALU), 'h0);
    checkVal("b2b_sub_zero", 64'(bus.zeroOutput), 'h1);
    bus.opCode = OP_AND; bus.input1 = 'h5555; bus.input2 = 'hAAAA;
    #1;
    checkVal("b2b_inReady", 64'(bus.inReady), 'h1);
    tick();
    checkVal("b2b_and_valid", 64'(bus.outValid), 'h1);
    checkVal("b2b_and_res", 64'(bus.outputALU), 'h0);
    checkVal("b2b_and_zero", 64'(bus.zeroOutput), 'h1);
    bus.inValid = 1'b0;
    tick();
    checkVal("b2b_idle", 64'(bus.outValid), 'h0);

    runOp("mul", OP_MUL, 'h00A7, 'h000F, 'h09C9, 1'b0, W + 1);
    runOp("slt", OP_SLT, 'h8000, 'h0001, 'h0001, 1'b0, 1);
    runOp("sll", OP_SLL, 'h0001, 'h0013, 'h0008, 1'b0, 1);

    // Backpressure on OR, next op waiting
    bus.inValid = 1'b1; bus.opCode = OP_OR; bus.input1 = 'h4000; bus.input2 = 'h0005;
    bus.outReady = 1'b0;
    tick();
    bus.opCode = OP_XOR; bus.input1 = 'h00FF; bus.input2 = 'h0F0F;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkVal("bp_valid", 64'(bus.outValid), 'h1);
      checkVal("bp_res", 64'(bus.outputALU), 'h4005);
      checkVal("bp_zero", 64'(bus.zeroOutput), 'h0);
      checkVal("bp_inReady", 64'(bus.inReady), 'h0);
      tick();
    end
    bus.outReady = 1'b1;
    #1;
    checkVal("bp_release_inReady", 64'(bus.inReady), 'h1);
    tick();
    checkVal("bp_next_valid", 64'(bus.outValid), 'h1);
    checkVal("bp_next_res", 64'(bus.outputALU), 'h0FF0);
    bus.inValid = 1'b0;
    tick();

`ifdef ALU_OVERFLOW_EN
    runOp("ovf_add", OP_ADD, 'h7FFF, 'h0001, 'h8000, 1'b1, 1);
    runOp("ovf_sub", OP_SUB, 'h8000, 'h0001, 'h7FFF, 1'b1, 1);
`endif

    // Reset four cycles into a MUL
    bus.inValid = 1'b1; bus.opCode = OP_MUL; bus.input1 = 'h1234; bus.input2 = 'h5678;
    tick();
    bus.inValid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    checkVal("midmul_rst_valid", 64'(bus.outValid), 'h0);
    checkVal("midmul_rst_inReady", 64'(bus.inReady), 'h0);
    checkVal("midmul_rst_res", 64'(bus.outputALU), 'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    checkVal("midmul_release_inReady", 64'(bus.inReady), 'h1);
    stale = 0;
    repeat (25) begin
      tick();
      if (bus.outValid) stale++;
    end
    checkVal("midmul_stale", 64'(stale), 'h0);
    runOp("post_rst_add", OP_ADD, 'h1234, 'h0001, 'h1235, 1'b0, 1);

    // WIDTH=8 instance
    bus8.inValid = 1'b1; bus8.opCode = OP_MUL; bus8.input1 = 'h0F; bus8.input2 = 'h11;
    tick();
    bus8.inValid = 1'b0;
    lat = 1;
    while (!bus8.outValid && lat < 40) begin
      tick();
      lat++;
    end
    checkVal("w8_mul_lat", 64'(lat), 'd9);
    checkVal("w8_mul_res", 64'(bus8.outputALU), 'hFF);
    tick();

    // Randomized stream with backpressure, scored against the reference model
    holdPend = 1'b0;
    holdRes  = '0;
    for (int c = 0; c < 1540; c++) begin
      if (c < 1500) begin
        bus.inValid  = ($urandom_range(0, 3) != 0);
        bus.outReady = ($urandom_range(0, 3) != 0);
        bus.opCode   = 3'($urandom_range(0, 7));
        bus.input1   = ($urandom_range(0, 7) == 0) ? W'(16'h8000) : W'($urandom);
        bus.input2   = ($urandom_range(0, 7) == 0) ? bus.input1 : W'($urandom);
      end else begin
        bus.inValid  = 1'b0;
        bus.outReady = 1'b1;
      end
      #1;
      if (holdPend) checkVal("rnd_hold", 64'({bus.outValid, bus.outputALU}), 64'({1'b1, holdRes}));
      holdPend = bus.outValid && !bus.outReady;
      holdRes  = bus.outputALU;
      if (bus.outValid && bus.outReady) begin
        checkVal("rnd_expected_pending", 64'(sbq.size() != 0), 'h1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          checkVal("rnd_res", 64'(bus.outputALU), 64'(e[W-1:0]));
          checkVal("rnd_zero", 64'(bus.zeroOutput), 64'(e[W-1:0] == '0));
`ifdef ALU_OVERFLOW_EN
          checkVal("rnd_ovf", 64'(bus.overflowOutput), 64'(e[W]));
`endif
        end
      end
      if (bus.inValid && bus.inReady)
        sbq.push_back({refOvf(bus.opCode, bus.input1, bus.input2),
                       refAlu(bus.opCode, bus.input1, bus.input2)});
      tick();
    end
    checkVal("rnd_drained", 64'(sbq.size()), 'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
